// File: rtl/counter_pkg.sv
// Shared constants for the programmable event/timer counter.
package counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: tick every PRE_DIV enabled cycles, synchronous clear.
module counter_prescaler #(
  parameter int unsigned PRE_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRE_DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] pre_q, pre_d;

  // With PRE_DIV=1, LAST is 0 and the register never leaves 0, so tick == en.
  assign tick = en && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q == LAST) pre_d = '0;
      else               pre_d = pre_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/counter_prog.sv
// Loadable up/down counter with prescaler, wrap/saturate, terminal-count and compare-match pulses.
module counter_prog
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRE_DIV  = 1,
  parameter int unsigned SAT_MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wr,
  input  logic             wr_cmp,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] data_cnt,
  output logic             tc,
  output logic             match
);

  localparam logic             SAT     = (SAT_MODE == MODE_SAT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_NMX = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             tc_q, tc_d;
  logic             match_q, match_d;
  logic             tick;

  counter_prescaler #(
    .PRE_DIV (PRE_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (wr),
    .tick  (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    cmp_d = cmp_q;
    tc_d  = 1'b0;
    if (wr_cmp) cmp_d = wdata;

    if (wr) begin
      cnt_d = wdata;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        if (cnt_q == CNT_MAX) begin
          if (!SAT) begin
            cnt_d = '0;
            tc_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          tc_d  = SAT && (cnt_q == CNT_NMX);
        end
      end else begin
        if (cnt_q == '0) begin
          if (!SAT) begin
            cnt_d = CNT_MAX;
            tc_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE;
          tc_d  = SAT && (cnt_q == ONE);
        end
      end
    end

    // A load always qualifies; a step only when the value actually moved onto cmp.
    match_d = (cnt_d == cmp_d) && (wr || (cnt_d != cnt_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      cmp_q   <= '0;
      tc_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      tc_q    <= tc_d;
      match_q <= match_d;
    end
  end

  assign data_cnt = cnt_q;
  assign tc       = tc_q;
  assign match    = match_q;

endmodule

// File: tb/tb_counter_prog.sv
// Directed bench for counter_prog: wrap, saturate and prescaled instances share stimulus.
module tb_counter_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wdata;
  logic       wr, wr_cmp, en, dir;

  logic [7:0] cnt_w, cnt_s, cnt_p;
  logic       tc_w, tc_s, tc_p;
  logic       m_w, m_s, m_p;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  counter_prog #(.WIDTH(8), .PRE_DIV(1), .SAT_MODE(0)) u_wrap (
    .clk(clk), .reset(reset), .wdata(wdata), .wr(wr), .wr_cmp(wr_cmp), .en(en), .dir(dir),
    .data_cnt(cnt_w), .tc(tc_w), .match(m_w));

  counter_prog #(.WIDTH(8), .PRE_DIV(1), .SAT_MODE(1)) u_sat (
    .clk(clk), .reset(reset), .wdata(wdata), .wr(wr), .wr_cmp(wr_cmp), .en(en), .dir(dir),
    .data_cnt(cnt_s), .tc(tc_s), .match(m_s));

  counter_prog #(.WIDTH(8), .PRE_DIV(4), .SAT_MODE(0)) u_pre (
    .clk(clk), .reset(reset), .wdata(wdata), .wr(wr), .wr_cmp(wr_cmp), .en(en), .dir(dir),
    .data_cnt(cnt_p), .tc(tc_p), .match(m_p));

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wdata = '0; wr = 0; wr_cmp = 0; en = 0; dir = 1;
    tick_clk(); tick_clk();
    checks++;
    if ({cnt_w, tc_w, m_w, cnt_s, tc_s, m_s, cnt_p, tc_p, m_p} !== '0) begin
      failures++;
      $display("FAIL reset_hold: w=%h/%b/%b s=%h/%b/%b p=%h/%b/%b required all zero",
               cnt_w, tc_w, m_w, cnt_s, tc_s, m_s, cnt_p, tc_p, m_p);
    end
    reset = 1'b1;
    wr = 1; wdata = 8'h33; en = 1; dir = 1;
    tick_clk(); wr = 0;
    tick_clk(); tick_clk();
    checks++;
    if (cnt_w !== 8'h35) begin failures++; $display("FAIL pre_reset_count: got %h want 35", cnt_w); end
    #5 reset = 1'b0;
    #2;
    checks++;
    if (cnt_w !== 8'h00 || cnt_s !== 8'h00 || cnt_p !== 8'h00) begin
      failures++; $display("FAIL async_reset: w=%h s=%h p=%h want 00", cnt_w, cnt_s, cnt_p);
    end
    en = 0;
    tick_clk();
    reset = 1'b1;
    tick_clk();
    checks++;
    if (cnt_w !== 8'h00 || tc_w !== 1'b0 || m_w !== 1'b0) begin
      failures++; $display("FAIL reset_release: cnt=%h tc=%b match=%b want 00/0/0", cnt_w, tc_w, m_w);
    end
  endtask

  task automatic test_load_count();
    logic [7:0] exp_v [3];
    exp_v[0] = 8'h55; exp_v[1] = 8'h56; exp_v[2] = 8'h57;
    wr = 1; wdata = 8'h55; en = 1; dir = 1;
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      wr = 0;
      checks++;
      if (cnt_w !== exp_v[i]) begin
        failures++; $display("FAIL load_count[%0d]: got %h want %h", i, cnt_w, exp_v[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ev [4];
    logic       et [4];
    logic       em [4];
    wr = 1; wdata = 8'hFE; en = 1; dir = 1;
    tick_clk(); wr = 0;
    checks++;
    if (cnt_w !== 8'hFE || tc_w !== 1'b0) begin
      failures++; $display("FAIL wrap_load: cnt=%h tc=%b want fe/0", cnt_w, tc_w);
    end
    ev = '{8'hFF, 8'h00, 8'h01, 8'h02}; et = '{0, 1, 0, 0}; em = '{0, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      checks++;
      if (cnt_w !== ev[i] || tc_w !== et[i] || m_w !== em[i]) begin
        failures++;
        $display("FAIL wrap_up[%0d]: cnt=%h tc=%b match=%b want %h/%b/%b",
                 i, cnt_w, tc_w, m_w, ev[i], et[i], em[i]);
      end
    end
    wr = 1; wdata = 8'h01; dir = 0;
    tick_clk(); wr = 0;
    ev = '{8'h00, 8'hFF, 8'hFE, 8'hFD}; et = '{0, 1, 0, 0}; em = '{1, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      checks++;
      if (cnt_w !== ev[i] || tc_w !== et[i] || m_w !== em[i]) begin
        failures++;
        $display("FAIL wrap_down[%0d]: cnt=%h tc=%b match=%b want %h/%b/%b",
                 i, cnt_w, tc_w, m_w, ev[i], et[i], em[i]);
      end
    end
    wr = 1; wdata = 8'hFF; en = 0;
    tick_clk(); wr = 0;
    checks++;
    if (cnt_w !== 8'hFF || tc_w !== 1'b0) begin
      failures++; $display("FAIL wrap_load_boundary: cnt=%h tc=%b want ff/0", cnt_w, tc_w);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] ev [5];
    logic       et [5];
    wr = 1; wdata = 8'hFD; en = 1; dir = 1;
    tick_clk(); wr = 0;
    ev = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFE}; et = '{0, 1, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) dir = 0;
      tick_clk();
      checks++;
      if (cnt_s !== ev[i] || tc_s !== et[i]) begin
        failures++; $display("FAIL sat_up[%0d]: cnt=%h tc=%b want %h/%b", i, cnt_s, tc_s, ev[i], et[i]);
      end
    end
    wr = 1; wdata = 8'h01;
    tick_clk(); wr = 0;
    tick_clk();
    checks++;
    if (cnt_s !== 8'h00 || tc_s !== 1'b1 || m_s !== 1'b1) begin
      failures++; $display("FAIL sat_reach_zero: cnt=%h tc=%b match=%b want 00/1/1", cnt_s, tc_s, m_s);
    end
    tick_clk();
    checks++;
    if (cnt_s !== 8'h00 || tc_s !== 1'b0 || m_s !== 1'b0) begin
      failures++; $display("FAIL sat_hold_zero: cnt=%h tc=%b match=%b want 00/0/0", cnt_s, tc_s, m_s);
    end
  endtask

  task automatic test_match();
    logic [7:0] ev [5];
    logic       em [5];
    en = 0; wr_cmp = 1; wdata = 8'h10;
    tick_clk(); wr_cmp = 0;
    checks++;
    if (m_w !== 1'b0) begin failures++; $display("FAIL cmp_write_nomatch: match=%b want 0", m_w); end
    wr = 1; wdata = 8'h0E; en = 1; dir = 1;
    ev = '{8'h0E, 8'h0F, 8'h10, 8'h10, 8'h10}; em = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      tick_clk();
      wr = 0;
      if (i == 2) en = 0;
      checks++;
      if (cnt_w !== ev[i] || m_w !== em[i]) begin
        failures++; $display("FAIL match_step[%0d]: cnt=%h match=%b want %h/%b", i, cnt_w, m_w, ev[i], em[i]);
      end
    end
    wr = 1; wdata = 8'h10;
    tick_clk(); wr = 0;
    checks++;
    if (cnt_w !== 8'h10 || m_w !== 1'b1) begin
      failures++; $display("FAIL match_load: cnt=%h match=%b want 10/1", cnt_w, m_w);
    end
    tick_clk();
    checks++;
    if (m_w !== 1'b0) begin failures++; $display("FAIL match_pulse_width: match=%b want 0", m_w); end
    wr_cmp = 1; wdata = 8'h10;
    tick_clk(); wr_cmp = 0;
    checks++;
    if (m_w !== 1'b0) begin failures++; $display("FAIL cmp_equal_count: match=%b want 0", m_w); end
  endtask

  task automatic test_dir();
    logic [7:0] ev [4];
    wr = 1; wdata = 8'h30; en = 1; dir = 1;
    tick_clk(); wr = 0;
    ev = '{8'h31, 8'h30, 8'h2F, 8'h30};
    for (int i = 0; i < 4; i++) begin
      dir = (i == 0 || i == 3);
      tick_clk();
      checks++;
      if (cnt_w !== ev[i]) begin failures++; $display("FAIL dir_change[%0d]: got %h want %h", i, cnt_w, ev[i]); end
    end
  endtask

  task automatic test_prescale();
    logic [7:0] ev [8];
    logic       en_pat [8];
    wr = 1; wdata = 8'h20; en = 1; dir = 1;
    tick_clk(); wr = 0;
    ev = '{8'h20, 8'h20, 8'h20, 8'h21, 8'h21, 8'h21, 8'h21, 8'h21};
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      checks++;
      if (cnt_p !== ev[i]) begin failures++; $display("FAIL pre_period[%0d]: got %h want %h", i, cnt_p, ev[i]); end
    end
    en_pat = '{1, 0, 1, 0, 1, 0, 1, 0};
    ev = '{8'h21, 8'h21, 8'h21, 8'h21, 8'h21, 8'h21, 8'h22, 8'h22};
    for (int i = 0; i < 8; i++) begin
      en = en_pat[i];
      tick_clk();
      checks++;
      if (cnt_p !== ev[i]) begin failures++; $display("FAIL pre_gated[%0d]: got %h want %h", i, cnt_p, ev[i]); end
    end
    en = 1;
    tick_clk(); tick_clk();
    wr = 1; wdata = 8'h40;
    tick_clk(); wr = 0;
    ev = '{8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      checks++;
      if (cnt_p !== ev[i]) begin failures++; $display("FAIL pre_restart[%0d]: got %h want %h", i, cnt_p, ev[i]); end
    end
    tick_clk(); tick_clk(); tick_clk();
    wr = 1; wdata = 8'h80;
    tick_clk(); wr = 0;
    checks++;
    if (cnt_p !== 8'h80 || tc_p !== 1'b0) begin
      failures++; $display("FAIL pre_load_wins: cnt=%h tc=%b want 80/0", cnt_p, tc_p);
    end
    tick_clk(); tick_clk(); tick_clk();
    checks++;
    if (cnt_p !== 8'h80) begin failures++; $display("FAIL pre_after_load_hold: got %h want 80", cnt_p); end
    tick_clk();
    checks++;
    if (cnt_p !== 8'h81) begin failures++; $display("FAIL pre_after_load_step: got %h want 81", cnt_p); end
  endtask

  initial begin
    test_reset();
    test_load_count();
    test_wrap();
    test_saturate();
    test_match();
    test_dir();
    test_prescale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
